// File: rtl/sound_ram_pkg.sv
// sound_ram_pkg: shared FSM state type and default constants for the sound RAM arbiter
package sound_ram_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DOC_ACC, ST_HOST_ACC} state_t;
    localparam logic [7:0] IDLE_DATA_DEFAULT = 8'h80;
    localparam int TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/sound_ram_arbiter_if.sv
// sound_ram_arbiter_if: DOC, host and memory signal bundle of the sound RAM arbiter
// DOC side : doc_rd_i/doc_addr_i fetch strobe, doc_data_ready_o/doc_data_o result
// host side: host_req_i level request with we/addr/data, host_ack_o pulse, host_data_o
// mem side : mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o command, mem_ready_i/mem_rdata_i
// status   : timeout_o sticky timeout flag
// slave is the arbiter's view, master the view of whatever drives it
interface sound_ram_arbiter_if;
    logic        doc_rd_i;
    logic [15:0] doc_addr_i;
    logic        doc_data_ready_o;
    logic [7:0]  doc_data_o;
    logic        host_req_i;
    logic        host_we_i;
    logic [15:0] host_addr_i;
    logic [7:0]  host_data_i;
    logic [7:0]  host_data_o;
    logic        host_ack_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_ready_i;
    logic [7:0]  mem_rdata_i;
    logic        timeout_o;
    modport slave (
        input  doc_rd_i, doc_addr_i, host_req_i, host_we_i, host_addr_i, host_data_i,
               mem_ready_i, mem_rdata_i,
        output doc_data_ready_o, doc_data_o, host_data_o, host_ack_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, timeout_o
    );
    modport master (
        output doc_rd_i, doc_addr_i, host_req_i, host_we_i, host_addr_i, host_data_i,
               mem_ready_i, mem_rdata_i,
        input  doc_data_ready_o, doc_data_o, host_data_o, host_ack_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, timeout_o
    );
endinterface

// File: rtl/sound_ram_arbiter.sv
// sound_ram_arbiter: shares one sound RAM between DOC wave fetches and host accesses
// clk_i     : system clock, rising edge
// reset_n_i : synchronous active-low reset
// bus       : sound_ram_arbiter_if.slave (DOC fetch, host request, memory command, timeout)
// One access in flight; DOC wins in IDLE except right after a DOC completion, when a
// waiting host goes first. Accesses without mem_ready_i end after TIMEOUT_CYCLES waits.
module sound_ram_arbiter
    import sound_ram_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter logic [7:0]  IDLE_DATA      = IDLE_DATA_DEFAULT
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    sound_ram_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

    state_t        r_state;
    state_t        w_next;
    logic          r_pend;
    logic [15:0]   r_pend_addr;
    logic [CW-1:0] r_cnt;
    logic          r_fair;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [15:0]   r_mem_addr;
    logic [7:0]    r_mem_wdata;
    logic          r_doc_rdy;
    logic [7:0]    r_doc_data;
    logic          r_host_ack;
    logic [7:0]    r_host_data;
    logic          r_timeout;
    logic          w_acc;
    logic          w_tmo;
    logic          w_done;
    logic [7:0]    w_rdata;
    logic          w_doc_req;
    logic          w_go_host;
    logic          w_go_doc;
    logic [15:0]   w_doc_addr;

    always_comb begin
        w_acc      = r_state != ST_IDLE;
        w_tmo      = w_acc && !bus.mem_ready_i && r_cnt == CW'(TIMEOUT_CYCLES);
        w_done     = w_acc && (bus.mem_ready_i || w_tmo);
        w_rdata    = bus.mem_ready_i ? bus.mem_rdata_i : IDLE_DATA;
        w_doc_req  = bus.doc_rd_i || r_pend;
        // r_fair marks the IDLE cycle right after a DOC completion; the host_ack_o
        // term stops a host that still holds its request from being served twice
        w_go_host  = r_state == ST_IDLE && bus.host_req_i && !r_host_ack && (r_fair || !w_doc_req);
        w_go_doc   = r_state == ST_IDLE && !w_go_host && w_doc_req;
        // a fresh strobe supersedes a pending address that has not been issued yet
        w_doc_addr = bus.doc_rd_i ? bus.doc_addr_i : r_pend_addr;
        w_next     = w_go_doc ? ST_DOC_ACC : w_go_host ? ST_HOST_ACC : w_done ? ST_IDLE : r_state;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) r_state <= ST_IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_cnt       <= '0;
            r_fair      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_doc_rdy   <= 1'b0;
            r_doc_data  <= IDLE_DATA;
            r_host_ack  <= 1'b0;
            r_host_data <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_doc_rdy  <= 1'b0;
            r_host_ack <= 1'b0;
            r_fair     <= 1'b0;
            if (bus.doc_rd_i) begin
                r_pend      <= !w_go_doc;
                r_pend_addr <= bus.doc_addr_i;
            end else if (w_go_doc) begin
                r_pend <= 1'b0;
            end
            if (w_go_doc || w_go_host) begin
                r_cnt      <= '0;
                r_mem_req  <= 1'b1;
                r_mem_we   <= w_go_host && bus.host_we_i;
                r_mem_addr <= w_go_doc ? w_doc_addr : bus.host_addr_i;
                if (w_go_host) r_mem_wdata <= bus.host_data_i;
            end else if (w_done) begin
                r_mem_req <= 1'b0;
                if (w_tmo) r_timeout <= 1'b1;
                if (r_state == ST_DOC_ACC) begin
                    r_doc_rdy  <= 1'b1;
                    r_doc_data <= w_rdata;
                    r_fair     <= 1'b1;
                end else begin
                    r_host_ack <= 1'b1;
                    if (!r_mem_we) r_host_data <= w_rdata;
                end
            end else if (w_acc) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.mem_req_o        = r_mem_req;
    assign bus.mem_we_o         = r_mem_we;
    assign bus.mem_addr_o       = r_mem_addr;
    assign bus.mem_wdata_o      = r_mem_wdata;
    assign bus.doc_data_ready_o = r_doc_rdy;
    assign bus.doc_data_o       = r_doc_data;
    assign bus.host_ack_o       = r_host_ack;
    assign bus.host_data_o      = r_host_data;
    assign bus.timeout_o        = r_timeout;
endmodule

// File: tb/tb_sound_ram_arbiter.sv
// tb_sound_ram_arbiter: vector table, directed corner sequences and random traffic against a RAM model
module tb_sound_ram_arbiter;
    localparam int TMO = 15;

    typedef struct {
        int rn, dr, da, hr, hw, ha, hd, rd, rdt;
        int er, ew, ea, ewd, edr, edd, eak, ehd, eto;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sound_ram_arbiter_if bus();

    sound_ram_arbiter #(.TIMEOUT_CYCLES(TMO), .IDLE_DATA(8'h80)) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .bus(bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    bit          auto_mem = 0;
    bit          spur = 0;
    int          mem_wait = 0;
    int          wcnt = 0;
    bit          prev_req = 0;
    bit          rise = 0;
    logic [15:0] rises[$];
    logic [7:0]  docs[$];
    int          n_ack = 0;
    vec_t        tv[16];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clock: observe at the falling edge, then let the memory model answer
    task automatic step();
        @(negedge clk);
        rise = bus.mem_req_o && !prev_req;
        prev_req = bus.mem_req_o;
        if (rise) rises.push_back(bus.mem_addr_o);
        if (bus.doc_data_ready_o) docs.push_back(bus.doc_data_o);
        if (bus.host_ack_o) n_ack++;
        if (auto_mem) begin
            if (bus.mem_req_o) begin
                if (wcnt >= mem_wait) begin
                    bus.mem_ready_i = 1'b1;
                    bus.mem_rdata_i = mem[bus.mem_addr_o];
                    if (bus.mem_we_o) mem[bus.mem_addr_o] = bus.mem_wdata_o;
                    wcnt = 0;
                end else begin
                    bus.mem_ready_i = 1'b0;
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                bus.mem_ready_i = spur && ($urandom_range(2) == 0);
                bus.mem_rdata_i = 8'($urandom);
            end
        end
    endtask

    initial begin
        bit          d_pend;
        logic [15:0] d_want, d_served;
        int          d_issued, d_done;
        bit          h_act;
        logic [15:0] h_addr;
        logic        h_we;
        logic [7:0]  h_wd, last_hd;
        int          h_docs, k;

        for (int a = 0; a < 65536; a++) begin
            mem[a] = 8'($urandom);
            ref_mem[a] = mem[a];
        end
        reset_n = 1'b0;
        bus.doc_rd_i = 1'b0;
        bus.doc_addr_i = '0;
        bus.host_req_i = 1'b0;
        bus.host_we_i = 1'b0;
        bus.host_addr_i = '0;
        bus.host_data_i = '0;
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = '0;

        //        rn dr da      hr hw ha      hd     rd rdt     er ew ea      ewd    edr edd    eak ehd    eto
        tv[0]  = '{0, 0, 'h0000, 0, 0, 'h0000, 'h00, 0, 'h00,  0, 0, 'h0000, 'h00, 0, 'h80, 0, 'h00, 0};
        tv[1]  = '{1, 1, 'h1234, 0, 0, 'h0000, 'h00, 0, 'h00,  1, 0, 'h1234, 'h00, 0, 'h80, 0, 'h00, 0};
        tv[2]  = '{1, 0, 'h0000, 0, 0, 'h0000, 'h00, 1, 'h5A,  0, 0, 'h0000, 'h00, 1, 'h5A, 0, 'h00, 0};
        tv[3]  = '{1, 0, 'h0000, 0, 0, 'h0000, 'h00, 1, 'h11,  0, 0, 'h0000, 'h00, 0, 'h5A, 0, 'h00, 0};
        tv[4]  = '{1, 0, 'h0000, 1, 1, 'h0100, 'hC3, 0, 'h00,  1, 1, 'h0100, 'hC3, 0, 'h5A, 0, 'h00, 0};
        tv[5]  = '{1, 0, 'h0000, 1, 1, 'h0100, 'hC3, 1, 'hEE,  0, 0, 'h0000, 'h00, 0, 'h5A, 1, 'h00, 0};
        tv[6]  = '{1, 0, 'h0000, 1, 1, 'h0100, 'hC3, 0, 'h00,  0, 0, 'h0000, 'h00, 0, 'h5A, 0, 'h00, 0};
        tv[7]  = '{1, 0, 'h0000, 1, 0, 'h0100, 'h00, 0, 'h00,  1, 0, 'h0100, 'h00, 0, 'h5A, 0, 'h00, 0};
        tv[8]  = '{1, 0, 'h0000, 1, 0, 'h0100, 'h00, 1, 'hC3,  0, 0, 'h0000, 'h00, 0, 'h5A, 1, 'hC3, 0};
        tv[9]  = '{1, 0, 'h0000, 0, 0, 'h0000, 'h00, 0, 'h00,  0, 0, 'h0000, 'h00, 0, 'h5A, 0, 'hC3, 0};
        tv[10] = '{1, 1, 'h2000, 1, 0, 'h3000, 'h00, 0, 'h00,  1, 0, 'h2000, 'h00, 0, 'h5A, 0, 'hC3, 0};
        tv[11] = '{1, 0, 'h0000, 1, 0, 'h3000, 'h00, 1, 'h77,  0, 0, 'h0000, 'h00, 1, 'h77, 0, 'hC3, 0};
        tv[12] = '{1, 1, 'h2001, 1, 0, 'h3000, 'h00, 0, 'h00,  1, 0, 'h3000, 'h00, 0, 'h77, 0, 'hC3, 0};
        tv[13] = '{1, 0, 'h0000, 1, 0, 'h3000, 'h00, 1, 'h44,  0, 0, 'h0000, 'h00, 0, 'h77, 1, 'h44, 0};
        tv[14] = '{1, 0, 'h0000, 1, 0, 'h3000, 'h00, 0, 'h00,  1, 0, 'h2001, 'h00, 0, 'h77, 0, 'h44, 0};
        tv[15] = '{1, 0, 'h0000, 0, 0, 'h0000, 'h00, 1, 'h99,  0, 0, 'h0000, 'h00, 1, 'h99, 0, 'h44, 0};

        for (int i = 0; i < 16; i++) begin
            reset_n         = 1'(tv[i].rn);
            bus.doc_rd_i    = 1'(tv[i].dr);
            bus.doc_addr_i  = 16'(tv[i].da);
            bus.host_req_i  = 1'(tv[i].hr);
            bus.host_we_i   = 1'(tv[i].hw);
            bus.host_addr_i = 16'(tv[i].ha);
            bus.host_data_i = 8'(tv[i].hd);
            bus.mem_ready_i = 1'(tv[i].rd);
            bus.mem_rdata_i = 8'(tv[i].rdt);
            step();
            chk($sformatf("v%0d mem_req", i), int'(bus.mem_req_o), tv[i].er);
            chk($sformatf("v%0d doc_ready", i), int'(bus.doc_data_ready_o), tv[i].edr);
            chk($sformatf("v%0d doc_data", i), int'(bus.doc_data_o), tv[i].edd);
            chk($sformatf("v%0d host_ack", i), int'(bus.host_ack_o), tv[i].eak);
            chk($sformatf("v%0d host_data", i), int'(bus.host_data_o), tv[i].ehd);
            chk($sformatf("v%0d timeout", i), int'(bus.timeout_o), tv[i].eto);
            if (tv[i].er != 0 || tv[i].rn == 0) begin
                chk($sformatf("v%0d mem_we", i), int'(bus.mem_we_o), tv[i].ew);
                chk($sformatf("v%0d mem_addr", i), int'(bus.mem_addr_o), tv[i].ea);
                chk($sformatf("v%0d mem_wdata", i), int'(bus.mem_wdata_o), tv[i].ewd);
            end
        end
        bus.doc_rd_i = 1'b0;
        bus.host_req_i = 1'b0;
        bus.mem_ready_i = 1'b0;
        step();

        // DOC read against silent memory
        bus.doc_rd_i = 1'b1;
        bus.doc_addr_i = 16'h4444;
        step();
        bus.doc_rd_i = 1'b0;
        chk("tmo doc mem_req rise", int'(bus.mem_req_o), 1);
        k = 0;
        while (!bus.doc_data_ready_o && k < 40) begin
            step();
            k++;
        end
        chk("tmo doc latency", k, 16);
        chk("tmo doc data", int'(bus.doc_data_o), 'h80);
        chk("tmo doc mem_req drop", int'(bus.mem_req_o), 0);
        chk("tmo flag set", int'(bus.timeout_o), 1);
        repeat (3) step();
        chk("tmo flag sticky", int'(bus.timeout_o), 1);

        // host read against silent memory
        bus.host_req_i = 1'b1;
        bus.host_we_i = 1'b0;
        bus.host_addr_i = 16'h6000;
        step();
        chk("tmo host mem_req rise", int'(bus.mem_req_o), 1);
        k = 0;
        while (!bus.host_ack_o && k < 40) begin
            step();
            k++;
        end
        bus.host_req_i = 1'b0;
        chk("tmo host latency", k, 16);
        chk("tmo host data", int'(bus.host_data_o), 'h80);
        step();

        // second fetch arrives while the first waits on a 3-wait memory
        auto_mem = 1;
        spur = 0;
        mem_wait = 3;
        mem[16'h0100] = 8'hA1;
        ref_mem[16'h0100] = 8'hA1;
        mem[16'h0200] = 8'hB2;
        ref_mem[16'h0200] = 8'hB2;
        rises.delete();
        docs.delete();
        bus.doc_rd_i = 1'b1;
        bus.doc_addr_i = 16'h0100;
        step();
        bus.doc_addr_i = 16'h0200;
        step();
        bus.doc_rd_i = 1'b0;
        k = 0;
        while (docs.size() < 2 && k < 40) begin
            step();
            k++;
        end
        chk("queue completions", docs.size(), 2);
        chk("queue accesses", rises.size(), 2);
        while (docs.size() < 2) docs.push_back(8'h00);
        while (rises.size() < 2) rises.push_back(16'h0000);
        chk("queue first data", int'(docs[0]), 'hA1);
        chk("queue second data", int'(docs[1]), 'hB2);
        chk("queue first addr", int'(rises[0]), 'h0100);
        chk("queue second addr", int'(rises[1]), 'h0200);
        chk("queue flag still sticky", int'(bus.timeout_o), 1);

        // reset while a host access waits on memory
        auto_mem = 0;
        bus.mem_ready_i = 1'b0;
        bus.host_req_i = 1'b1;
        bus.host_we_i = 1'b0;
        bus.host_addr_i = 16'h5555;
        step();
        chk("rst host issued", int'(bus.mem_req_o), 1);
        step();
        reset_n = 1'b0;
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 8'h5A;
        n_ack = 0;
        step();
        chk("rst mem_req", int'(bus.mem_req_o), 0);
        chk("rst mem_we", int'(bus.mem_we_o), 0);
        chk("rst mem_addr", int'(bus.mem_addr_o), 0);
        chk("rst mem_wdata", int'(bus.mem_wdata_o), 0);
        chk("rst doc_ready", int'(bus.doc_data_ready_o), 0);
        chk("rst doc_data", int'(bus.doc_data_o), 'h80);
        chk("rst host_ack", int'(bus.host_ack_o), 0);
        chk("rst host_data", int'(bus.host_data_o), 0);
        chk("rst timeout", int'(bus.timeout_o), 0);
        reset_n = 1'b1;
        bus.host_req_i = 1'b0;
        bus.mem_ready_i = 1'b0;
        repeat (4) step();
        chk("rst no stale ack", n_ack, 0);
        chk("rst stays idle", int'(bus.mem_req_o), 0);

        // random traffic: DOC on even addresses, host on odd, checked against a RAM model
        auto_mem = 1;
        spur = 1;
        d_pend = 0;
        d_want = '0;
        d_served = '0;
        d_issued = 0;
        d_done = 0;
        h_act = 0;
        h_addr = '0;
        h_we = 1'b0;
        h_wd = '0;
        h_docs = 0;
        last_hd = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (!bus.mem_req_o) mem_wait = $urandom_range(4);
            if (rise) begin
                if (!bus.mem_addr_o[0]) begin
                    chk("rnd doc issue wanted", int'(d_pend), 1);
                    chk("rnd doc addr", int'(bus.mem_addr_o), int'(d_want));
                    chk("rnd doc we", int'(bus.mem_we_o), 0);
                    d_pend = 0;
                    d_served = bus.mem_addr_o;
                    d_issued++;
                    if (h_act) h_docs++;
                end else begin
                    chk("rnd host issue wanted", int'(h_act), 1);
                    chk("rnd host addr", int'(bus.mem_addr_o), int'(h_addr));
                    chk("rnd host we", int'(bus.mem_we_o), int'(h_we));
                    if (h_we) chk("rnd host wdata", int'(bus.mem_wdata_o), int'(h_wd));
                end
            end
            if (bus.doc_data_ready_o) begin
                chk("rnd doc data", int'(bus.doc_data_o), int'(ref_mem[d_served]));
                d_done++;
            end
            if (bus.host_ack_o) begin
                chk("rnd host ack wanted", int'(h_act), 1);
                if (h_we) begin
                    ref_mem[h_addr] = h_wd;
                    chk("rnd host data kept on write", int'(bus.host_data_o), int'(last_hd));
                end else begin
                    chk("rnd host read data", int'(bus.host_data_o), int'(ref_mem[h_addr]));
                    last_hd = ref_mem[h_addr];
                end
                chk("rnd host fairness", int'(h_docs <= 1), 1);
                h_act = 0;
                bus.host_req_i = 1'b0;
            end
            bus.doc_rd_i = 1'b0;
            if (c < 2900) begin
                if (!h_act && $urandom_range(3) == 0) begin
                    h_act = 1;
                    h_docs = 0;
                    h_addr = {15'($urandom), 1'b1};
                    h_we = 1'($urandom);
                    h_wd = 8'($urandom);
                    bus.host_addr_i = h_addr;
                    bus.host_we_i = h_we;
                    bus.host_data_i = h_wd;
                    bus.host_req_i = 1'b1;
                end
                if ($urandom_range(5) == 0) begin
                    bus.doc_rd_i = 1'b1;
                    bus.doc_addr_i = {15'($urandom), 1'b0};
                    d_want = bus.doc_addr_i;
                    d_pend = 1;
                end
            end
        end
        chk("rnd doc drained", int'(d_pend), 0);
        chk("rnd host drained", int'(h_act), 0);
        chk("rnd doc issued vs done", d_done, d_issued);
        chk("rnd no timeout", int'(bus.timeout_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
